pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/halt controller: the FSM state
// encoding and the length of the drain sequence before the core parks.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter for the statistics. It sticks at all-ones and never
// wraps back to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall, flush and halt controller for a five-stage pipeline. Hazard responses
// are combinational so they take effect in the same cycle the hazard is seen.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             exe_mem_read,
  input  logic [4:0]       exe_wr_reg,
  input  logic             exe_branch_taken,
  input  logic             resume,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             id_exe_go,
  output logic             if_id_clear,
  output logic             id_exe_clear_one,
  output logic             id_exe_clear_two,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t     state_reg, state_next;
  logic [1:0] drain_cnt_reg, drain_cnt_next;
  logic       load_use;
  logic       stall_ev;
  logic       flush_ev;

  assign load_use = exe_mem_read && (exe_wr_reg != 5'd0) &&
                    ((id_uses_rs && (id_rs == exe_wr_reg)) ||
                     (id_uses_rt && (id_rt == exe_wr_reg)));

  // A taken branch squashes the ID instruction, so its hazards are moot.
  assign flush_ev = (state_reg == RUN) && exe_branch_taken;
  assign stall_ev = (state_reg == RUN) && !exe_branch_taken && load_use;

  always_comb begin
    pc_go            = 1'b1;
    if_id_go         = 1'b1;
    id_exe_go        = 1'b1;
    if_id_clear      = 1'b0;
    id_exe_clear_one = 1'b0;
    id_exe_clear_two = 1'b0;
    state_next       = state_reg;
    drain_cnt_next   = drain_cnt_reg;

    if (rst) begin
      if_id_clear      = 1'b1;
      id_exe_clear_one = 1'b1;
      state_next       = RUN;
      drain_cnt_next   = 2'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (exe_branch_taken) begin
            if_id_clear      = 1'b1;
            id_exe_clear_two = 1'b1;
          end else if (load_use || id_halt) begin
            pc_go            = 1'b0;
            if_id_go         = 1'b0;
            id_exe_clear_one = 1'b1;
            if (!load_use) begin
              state_next     = DRAIN;
              drain_cnt_next = 2'd0;
            end
          end
        end
        DRAIN: begin
          pc_go            = 1'b0;
          if_id_go         = 1'b0;
          id_exe_clear_one = 1'b1;
          if (drain_cnt_reg == 2'(DRAIN_CYCLES - 1)) begin
            state_next     = HALTED;
            drain_cnt_next = 2'd0;
          end else begin
            drain_cnt_next = drain_cnt_reg + 2'd1;
          end
        end
        HALTED: begin
          pc_go     = 1'b0;
          if_id_go  = 1'b0;
          id_exe_go = 1'b0;
          // Resume lets the successor in while bubbling the parked halt.
          if (resume) begin
            pc_go            = 1'b1;
            if_id_go         = 1'b1;
            id_exe_go        = 1'b1;
            id_exe_clear_one = 1'b1;
            state_next       = RUN;
          end
        end
        default: begin
          state_next     = RUN;
          drain_cnt_next = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_reg     <= state_next;
    drain_cnt_reg <= drain_cnt_next;
  end

  assign halted = (state_reg == HALTED) && !rst;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_reg != HALTED),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_ev),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_ev),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, flush, halt/resume, reset and
// counter saturation (second instance with 4-bit counters).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, exe_wr_reg;
  logic        id_uses_rs, id_uses_rt, id_halt, exe_mem_read, exe_branch_taken, resume;

  logic        pc_go, if_id_go, id_exe_go, if_id_clear, id_exe_clear_one, id_exe_clear_two, halted;
  logic [15:0] cycle_cnt, stall_cnt, flush_cnt;

  logic        pc_go4, if_id_go4, id_exe_go4, if_id_clear4, clr_one4, clr_two4, halted4;
  logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_cyc      = 0;

  // Packed control word: {pc_go, if_id_go, id_exe_go, if_id_clear, clear_one, clear_two, halted}
  localparam logic [6:0] C_NORM   = 7'b111_000_0;
  localparam logic [6:0] C_FLUSH  = 7'b111_101_0;
  localparam logic [6:0] C_STALL  = 7'b001_010_0;
  localparam logic [6:0] C_HALT   = 7'b000_000_1;
  localparam logic [6:0] C_RESUME = 7'b111_010_1;
  localparam logic [6:0] C_RST    = 7'b111_110_0;

  logic [6:0] ctl;
  assign ctl = {pc_go, if_id_go, id_exe_go, if_id_clear, id_exe_clear_one, id_exe_clear_two, halted};

  always #5 clk = ~clk;

  pipeline_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
    .exe_mem_read(exe_mem_read), .exe_wr_reg(exe_wr_reg),
    .exe_branch_taken(exe_branch_taken), .resume(resume),
    .pc_go(pc_go), .if_id_go(if_id_go), .id_exe_go(id_exe_go),
    .if_id_clear(if_id_clear), .id_exe_clear_one(id_exe_clear_one),
    .id_exe_clear_two(id_exe_clear_two), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) u_dut_w4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
    .exe_mem_read(exe_mem_read), .exe_wr_reg(exe_wr_reg),
    .exe_branch_taken(exe_branch_taken), .resume(resume),
    .pc_go(pc_go4), .if_id_go(if_id_go4), .id_exe_go(id_exe_go4),
    .if_id_clear(if_id_clear4), .id_exe_clear_one(clr_one4),
    .id_exe_clear_two(clr_two4), .halted(halted4),
    .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; exe_wr_reg = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_halt = 1'b0;
    exe_mem_read = 1'b0; exe_branch_taken = 1'b0; resume = 1'b0;
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    exe_mem_read = 1'b1; exe_wr_reg = r; id_rs = r; id_uses_rs = 1'b1;
  endtask

  // Let combinational outputs settle: sample mid-cycle on the falling edge.
  task automatic settle();
    #4;
  endtask

  // Cross one rising edge; counted tells whether cycle_cnt should advance.
  task automatic advance(input bit counted);
    @(posedge clk);
    #1;
    if (counted) exp_cyc++;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    settle();
    check("reset_ctl", 32'(ctl), 32'(C_RST));
    advance(0);
    check("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    settle();
    check("run_idle", 32'(ctl), 32'(C_NORM));
    advance(1);
    check("cycle_cnt_1", 32'(cycle_cnt), 32'(exp_cyc));

    // Load-use on rs
    load_use_rs(5'd8);
    settle();
    check("lu_rs_ctl", 32'(ctl), 32'(C_STALL));
    advance(1);
    idle();
    settle();
    check("lu_rs_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_after_ctl", 32'(ctl), 32'(C_NORM));
    advance(1);

    // Load-use on rt, then same registers with rt unused
    exe_mem_read = 1'b1; exe_wr_reg = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    settle();
    check("lu_rt_ctl", 32'(ctl), 32'(C_STALL));
    advance(1);
    id_uses_rt = 1'b0;
    settle();
    check("rt_unused_ctl", 32'(ctl), 32'(C_NORM));
    check("lu_rt_stall_cnt", 32'(stall_cnt), 32'd2);
    advance(1);

    // Register zero never stalls
    idle();
    load_use_rs(5'd0);
    settle();
    check("zero_reg_ctl", 32'(ctl), 32'(C_NORM));
    advance(1);
    idle();
    settle();
    check("zero_reg_stall_cnt", 32'(stall_cnt), 32'd2);

    // Branch wins over load-use, then over halt
    load_use_rs(5'd9);
    exe_branch_taken = 1'b1;
    settle();
    check("br_lu_ctl", 32'(ctl), 32'(C_FLUSH));
    advance(1);
    idle();
    exe_branch_taken = 1'b1; id_halt = 1'b1;
    settle();
    check("br_halt_ctl", 32'(ctl), 32'(C_FLUSH));
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd2);
    advance(1);
    idle();
    settle();
    check("br_after_ctl", 32'(ctl), 32'(C_NORM));
    check("br_flush_cnt2", 32'(flush_cnt), 32'd2);
    advance(1);

    // Halt at T: bubbles T..T+3, halted T+4, resume T+6
    id_halt = 1'b1;
    settle();
    check("halt_T", 32'(ctl), 32'(C_STALL));
    advance(1);
    idle();
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) begin
        exe_branch_taken = 1'b1; id_halt = 1'b1; resume = 1'b1;
      end else begin
        idle();
      end
      settle();
      check($sformatf("drain_T+%0d", i), 32'(ctl), 32'(C_STALL));
      advance(1);
    end
    idle();
    settle();
    check("halted_T+4", 32'(ctl), 32'(C_HALT));
    check("halted_cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
    advance(0);
    id_halt = 1'b1;
    settle();
    check("halted_T+5", 32'(ctl), 32'(C_HALT));
    advance(0);
    idle();
    resume = 1'b1;
    settle();
    check("resume_T+6", 32'(ctl), 32'(C_RESUME));
    check("frozen_cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
    advance(0);
    idle();
    settle();
    check("run_T+7", 32'(ctl), 32'(C_NORM));
    check("run_T+7_cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
    advance(1);

    // Reset two cycles into a halt sequence
    id_halt = 1'b1;
    settle();
    advance(1);
    idle();
    settle();
    check("mid_drain_ctl", 32'(ctl), 32'(C_STALL));
    advance(1);
    rst = 1'b1;
    settle();
    check("rst_mid_drain_ctl", 32'(ctl), 32'(C_RST));
    advance(0);
    exp_cyc = 0;
    rst = 1'b0;
    settle();
    check("post_rst_ctl", 32'(ctl), 32'(C_NORM));
    check("post_rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Saturation: 20 load-use cycles
    for (int i = 0; i < 20; i++) begin
      load_use_rs(5'd3);
      settle();
      advance(1);
    end
    idle();
    settle();
    check("sat_stall_cnt16", 32'(stall_cnt), 32'd20);
    check("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
    check("sat_cycle_cnt4", 32'(cycle_cnt4), 32'd15);
    check("sat_cycle_cnt16", 32'(cycle_cnt), 32'(exp_cyc));
    advance(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
